grid_write_arbiter: RTL
=======================

Name: grid_write_arbiter

Overview:
- Shares the single write port of the 64x48 snake grid store among three game-side requesters: 0 = head draw, 1 = tail erase, 2 = food place.
- Round-robin arbitration; address computed from x/y; writes optionally confined to vertical blank so the VGA scan never sees a half-updated frame.
- Owns a full-grid clear sequence used at game start.
- Sits between game-logic requesters and the grid storage that feeds the VGA interface.

Parameters:
GRID_W, 64, grid columns; cell index = y*GRID_W + x
GRID_H, 48, grid rows
GATE_VBLANK, 1, 1 = arbitrated writes granted only while vblank=1; 0 = ungated
CLEAR_VAL, 2'b00, cell value written by the clear sweep

Ports:
clk  input  1  system clock (50 MHz)
reset  input  1  synchronous, active-high reset
vblank  input  1  high during VGA vertical blanking
clear_start  input  1  request full-grid clear (level sampled)
clear_done  output  1  one-cycle pulse after the last clear write
req  input  3  per-requester write request
req_x  input  18  3 x 6-bit column; requester i at [6i+5:6i]
req_y  input  18  3 x 6-bit row; same packing
req_val  input  6  3 x 2-bit cell value; requester i at [2i+1:2i]
gnt  output  3  one-cycle grant pulse, at most one bit set
err  output  3  one-cycle pulse with gnt when coordinates out of range
grid_we  output  1  grid write enable
grid_addr  output  12  cell index 0..3071
grid_wdata  output  2  cell value
busy  output  1  high while the clear sweep is in progress
write_count  output  16  successful arbitrated writes, wraps 0xFFFF->0x0000

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high): all outputs 0, state IDLE, round-robin pointer = 0 (requester 0 highest priority). A reset during CLEAR aborts the sweep with no clear_done.
- States: IDLE (arbitrating), CLEAR (sweeping).
- Arbitration, IDLE:
  - Sample at edge N; results visible in cycle N+1.
  - Eligible requester: req[i]=1, gnt[i]=0 in the current cycle, and vblank=1 (or GATE_VBLANK=0).
  - Pick the first eligible requester starting from the pointer, searching upward mod 3. Pointer <= winner+1 mod 3.
- Write on grant:
  - Cycle N+1: gnt[winner]=1, grid_we=1, grid_addr = y*GRID_W+x, grid_wdata = req_val slice, write_count+1.
  - If x>=GRID_W or y>=GRID_H: gnt and err pulse together, grid_we=0, count unchanged. The pointer still advances.
- Requester handshake:
  - Hold req and payload stable until gnt is seen; drop req or present new data on the next edge.
  - Arbiter masks req[i] while gnt[i]=1, so a requester is granted at most every other cycle.
  - With all three requesting continuously, grants rotate 0,1,2,0,... on alternate-free cycles, i.e. one grant per cycle overall.
  - A req withdrawn before grant is legal and is simply not granted.
- Clear:
  - clear_start sampled high in IDLE at edge N takes priority over pending requests; no gnt at N+1.
  - busy=1 from N+1 through the final write cycle.
  - grid_we=1 at N+1..N+3072 with grid_addr 0..3071 ascending and grid_wdata=CLEAR_VAL. The sweep ignores vblank.
  - Cycle N+3073: clear_done=1, busy=0, state IDLE. Requests sampled at edge N+3073 produce grants from N+3074.
  - clear_start in CLEAR is ignored. clear_start still high on return to IDLE starts a new sweep.
  - Clear writes do not change write_count or the pointer.
- Outside write cycles, grid_addr and grid_wdata hold their last value; only grid_we qualifies them.

Test Plan:
- Reset then vblank=1, req=3'b001, x=5, y=2, val=2'b10: next cycle gnt=001, grid_we=1, grid_addr=133, grid_wdata=10, write_count=1.
- req=3'b111 held continuously, vblank=1: gnt sequence 001,010,100,001,... with no idle cycles; grid_addr tracks each requester's x/y.
- GATE_VBLANK=1, vblank=0, req=3'b010 for 10 cycles: no gnt, grid_we=0. vblank rises: gnt=010 one cycle later.
- req=3'b100, y=48, x=0: gnt=100 and err=100 same cycle, grid_we=0, write_count unchanged.
- clear_start pulse with req=3'b001 pending: 3072 writes, addr 0..3071, data CLEAR_VAL, busy high throughout, no gnt. clear_done one cycle after addr 3071; gnt=001 on the following cycle.
- reset asserted at clear address 1000: next cycle all outputs 0 and no clear_done; a subsequent request is granted normally with pointer at 0.

Source files
------------

// File: rtl/grid_write_arbiter_if.sv
// Bundle of the grid write-arbiter signals: game-side requests, VGA blanking,
// clear control and the single grid write port.
interface grid_write_arbiter_if;
  logic        vblank;
  logic        clear_start;
  logic        clear_done;
  logic [2:0]  req;
  logic [17:0] req_x;
  logic [17:0] req_y;
  logic [5:0]  req_val;
  logic [2:0]  gnt;
  logic [2:0]  err;
  logic        grid_we;
  logic [11:0] grid_addr;
  logic [1:0]  grid_wdata;
  logic        busy;
  logic [15:0] write_count;

  modport master (
    output vblank, clear_start, req, req_x, req_y, req_val,
    input  clear_done, gnt, err, grid_we, grid_addr, grid_wdata, busy, write_count
  );

  modport slave (
    input  vblank, clear_start, req, req_x, req_y, req_val,
    output clear_done, gnt, err, grid_we, grid_addr, grid_wdata, busy, write_count
  );
endinterface

// File: rtl/grid_write_arbiter.sv
// Round-robin arbiter for the single write port of the snake grid store.
// Three requesters (head draw, tail erase, food place) share the port; writes
// can be confined to vertical blank, and a full-grid clear sweep can take
// over the port at game start.
module grid_write_arbiter #(
  parameter int         GRID_W      = 64,
  parameter int         GRID_H      = 48,
  parameter bit         GATE_VBLANK = 1'b1,
  parameter logic [1:0] CLEAR_VAL   = 2'b00
) (
  input  logic clk,
  input  logic reset,
  grid_write_arbiter_if.slave bus
);

  localparam logic [11:0] LAST_ADDR = 12'(GRID_W * GRID_H - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state, state_nxt;
  logic [1:0]  ptr, ptr_nxt;
  logic [2:0]  gnt_nxt, err_nxt;
  logic        we_nxt, busy_nxt, done_nxt;
  logic [11:0] addr_nxt;
  logic [1:0]  wdata_nxt;
  logic [15:0] cnt_nxt;

  logic [2:0]  elig;
  logic        found;
  logic [1:0]  win;
  logic [2:0]  idx;
  logic [5:0]  sel_x, sel_y;
  logic [1:0]  sel_val;
  logic        oob;
  logic [11:0] addr_calc;

  // A requester granted this cycle is masked so it cannot be granted twice
  // on the same held request.
  assign elig = bus.req & ~bus.gnt & {3{bus.vblank | ~GATE_VBLANK}};

  // Search for the first eligible requester starting at the pointer, mod 3.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 3'd0;
    for (int k = 0; k < 3; k++) begin
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!found && elig[idx[1:0]]) begin
        found = 1'b1;
        win   = idx[1:0];
      end
    end
  end

  assign sel_x     = bus.req_x[6*win +: 6];
  assign sel_y     = bus.req_y[6*win +: 6];
  assign sel_val   = bus.req_val[2*win +: 2];
  assign oob       = (int'(sel_x) >= GRID_W) || (int'(sel_y) >= GRID_H);
  assign addr_calc = 12'(sel_y) * 12'(GRID_W) + 12'(sel_x);

  // Next-state and next-output decode for arbitration and the clear sweep.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = 3'b000;
    err_nxt   = 3'b000;
    we_nxt    = 1'b0;
    addr_nxt  = bus.grid_addr;
    wdata_nxt = bus.grid_wdata;
    busy_nxt  = bus.busy;
    done_nxt  = 1'b0;
    cnt_nxt   = bus.write_count;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (bus.clear_start) begin
          // Clear wins over pending requests; first sweep write is address 0.
          state_nxt = CLEAR;
          busy_nxt  = 1'b1;
          we_nxt    = 1'b1;
          addr_nxt  = 12'd0;
          wdata_nxt = CLEAR_VAL;
        end else if (found) begin
          gnt_nxt = 3'b001 << win;
          ptr_nxt = (win == 2'd2) ? 2'd0 : win + 2'd1;
          if (oob) begin
            // Bad coordinates are acknowledged but never reach the grid.
            err_nxt = 3'b001 << win;
          end else begin
            we_nxt    = 1'b1;
            addr_nxt  = addr_calc;
            wdata_nxt = sel_val;
            cnt_nxt   = bus.write_count + 16'd1;
          end
        end
      end
      CLEAR: begin
        if (bus.grid_addr == LAST_ADDR) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          we_nxt    = 1'b1;
          addr_nxt  = bus.grid_addr + 12'd1;
          wdata_nxt = CLEAR_VAL;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; the grid address doubles as sweep counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      ptr             <= 2'd0;
      bus.gnt         <= 3'b000;
      bus.err         <= 3'b000;
      bus.grid_we     <= 1'b0;
      bus.grid_addr   <= 12'd0;
      bus.grid_wdata  <= 2'b00;
      bus.busy        <= 1'b0;
      bus.clear_done  <= 1'b0;
      bus.write_count <= 16'd0;
    end else begin
      state           <= state_nxt;
      ptr             <= ptr_nxt;
      bus.gnt         <= gnt_nxt;
      bus.err         <= err_nxt;
      bus.grid_we     <= we_nxt;
      bus.grid_addr   <= addr_nxt;
      bus.grid_wdata  <= wdata_nxt;
      bus.busy        <= busy_nxt;
      bus.clear_done  <= done_nxt;
      bus.write_count <= cnt_nxt;
    end
  end

endmodule
